// File: rtl/turn_scheduler.sv
// Turn sequencer and fire-request arbiter for the two-player battleship datapath.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT idle ARMED cycles.
module turn_scheduler #(
  parameter int WIN_SCORE = 4,
  parameter int TIMEOUT   = 500,
  parameter int TW        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pA_req,
  input  logic       pB_req,
  input  logic [1:0] X,
  input  logic [1:0] Y,
  output logic       fire_valid,
  input  logic       fire_ready,
  output logic       fire_player,
  output logic [1:0] fire_x,
  output logic [1:0] fire_y,
  input  logic       result_valid,
  input  logic       result_hit,
  output logic       turn,
  output logic [2:0] score_a,
  output logic [2:0] score_b,
  output logic       game_over,
  output logic       winner,
  output logic       illegal_pulse,
  output logic       timeout_pulse,
  output logic [2:0] state
);

  if (WIN_SCORE < 1 || WIN_SCORE > 7) begin : g_bad_win
    $error("turn_scheduler: WIN_SCORE must be in 1..7");
  end
  if (TIMEOUT < 2 || TW < 1 || TW > 30 || (1 << TW) <= TIMEOUT) begin : g_bad_timeout
    $error("turn_scheduler: need TIMEOUT >= 2 and 2**TW > TIMEOUT");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    UPDATE   = 3'd4,
    OVER     = 3'd5
  } state_t;

  localparam logic [2:0] WIN = 3'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       turn_d, fire_player_d, game_over_d, winner_d, illegal_d;
  logic [1:0] fire_x_d, fire_y_d;
  logic [2:0] score_a_d, score_b_d;
  logic       accept, expire;
  logic [2:0] shooter_score;

  assign state         = state_q;
  assign fire_valid    = (state_q == ISSUE);
  assign accept        = turn ? pB_req : pA_req;
  assign shooter_score = fire_player ? score_b : score_a;

`ifdef TURN_TIMEOUT_EN
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] cnt;

  // An accepted request on the expiry cycle wins over the forfeit.
  assign expire = (state_q == ARMED) && !accept && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= expire;
      if (state_q != ARMED || accept || expire) cnt <= '0;
      else                                      cnt <= cnt + TW'(1);
    end
  end
`else
  assign expire        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    turn_d        = turn;
    score_a_d     = score_a;
    score_b_d     = score_b;
    fire_player_d = fire_player;
    fire_x_d      = fire_x;
    fire_y_d      = fire_y;
    game_over_d   = game_over;
    winner_d      = winner;
    illegal_d     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d   = ARMED;
        turn_d    = 1'b0;
        score_a_d = '0;
        score_b_d = '0;
      end
      ARMED: begin
        illegal_d = turn ? pA_req : pB_req;
        if (accept) begin
          fire_x_d      = X;
          fire_y_d      = Y;
          fire_player_d = turn;
          state_d       = ISSUE;
        end else if (expire) begin
          turn_d = ~turn;
        end
      end
      ISSUE: if (fire_ready) state_d = WAIT_RES;
      WAIT_RES: if (result_valid) begin
        if (result_hit) begin
          if (fire_player) score_b_d = score_b + 3'd1;
          else             score_a_d = score_a + 3'd1;
        end
        state_d = UPDATE;
      end
      UPDATE: if (shooter_score == WIN) begin
        state_d     = OVER;
        game_over_d = 1'b1;
        winner_d    = fire_player;
      end else begin
        turn_d  = ~turn;
        state_d = ARMED;
      end
      OVER: if (start) begin
        state_d     = IDLE;
        game_over_d = 1'b0;
        score_a_d   = '0;
        score_b_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      turn          <= 1'b0;
      score_a       <= '0;
      score_b       <= '0;
      fire_player   <= 1'b0;
      fire_x        <= '0;
      fire_y        <= '0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      illegal_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q       <= state_d;
      turn          <= turn_d;
      score_a       <= score_a_d;
      score_b       <= score_b_d;
      fire_player   <= fire_player_d;
      fire_x        <= fire_x_d;
      fire_y        <= fire_y_d;
      game_over     <= game_over_d;
      winner        <= winner_d;
      illegal_pulse <= illegal_d;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed vector table, hand-written corner
// sequences and a randomized run against a game-rules reference model.
module tb_turn_scheduler;

  localparam int WIN = 2;
  localparam int TMO = 10;
  localparam int TWW = 4;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk, rst, start, pA_req, pB_req;
  logic [1:0] X, Y;
  logic       fire_valid, fire_ready, fire_player;
  logic [1:0] fire_x, fire_y;
  logic       result_valid, result_hit, turn;
  logic [2:0] score_a, score_b;
  logic       game_over, winner, illegal_pulse, timeout_pulse;
  logic [2:0] state;

  turn_scheduler #(.WIN_SCORE(WIN), .TIMEOUT(TMO), .TW(TWW)) dut (
    .clk(clk), .rst(rst), .start(start), .pA_req(pA_req), .pB_req(pB_req),
    .X(X), .Y(Y), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_player(fire_player), .fire_x(fire_x), .fire_y(fire_y),
    .result_valid(result_valid), .result_hit(result_hit), .turn(turn),
    .score_a(score_a), .score_b(score_b), .game_over(game_over), .winner(winner),
    .illegal_pulse(illegal_pulse), .timeout_pulse(timeout_pulse), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r, start, pa, pb;
    logic [1:0] x, y;
    logic rdy, rv, hit;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [2:0] st;
    logic       tn;
    logic [2:0] sa, sb;
    logic       fv, fp;
    logic [1:0] fx, fy;
    logic       ill, go;
  } vec_t;

  function automatic stim_t mk_s(logic st, logic pa, logic pb, logic [1:0] x, logic [1:0] y,
                                 logic rdy, logic rv, logic hit);
    stim_t s;
    s.r = 1'b0; s.start = st; s.pa = pa; s.pb = pb; s.x = x; s.y = y;
    s.rdy = rdy; s.rv = rv; s.hit = hit;
    return s;
  endfunction

  function automatic vec_t mk_v(stim_t s, logic [2:0] st, logic tn, logic [2:0] sa, logic [2:0] sb,
                                logic fv, logic fp, logic [1:0] fx, logic [1:0] fy,
                                logic ill, logic go);
    vec_t v;
    v.s = s; v.st = st; v.tn = tn; v.sa = sa; v.sb = sb; v.fv = fv; v.fp = fp;
    v.fx = fx; v.fy = fy; v.ill = ill; v.go = go;
    return v;
  endfunction

  // Reference model: game rules tracked with plain integers.
  int m_ph, m_turn, m_sa, m_sb, m_fp, m_fx, m_fy, m_go, m_win, m_ill, m_to, m_idle;

  task automatic model_reset();
    m_ph = 0; m_turn = 0; m_sa = 0; m_sb = 0; m_fp = 0; m_fx = 0; m_fy = 0;
    m_go = 0; m_win = 0; m_ill = 0; m_to = 0; m_idle = 0;
  endtask

  task automatic model_step(input stim_t s);
    int mine, other, sc;
    if (s.r) begin
      model_reset();
      return;
    end
    m_ill = 0;
    m_to  = 0;
    case (m_ph)
      0: if (s.start) begin m_ph = 1; m_turn = 0; m_sa = 0; m_sb = 0; m_idle = 0; end
      1: begin
        mine  = m_turn ? int'(s.pb) : int'(s.pa);
        other = m_turn ? int'(s.pa) : int'(s.pb);
        m_ill = other;
        if (mine != 0) begin
          m_fx = int'(s.x); m_fy = int'(s.y); m_fp = m_turn; m_ph = 2;
        end else if (TO_EN) begin
          m_idle++;
          if (m_idle == TMO) begin m_turn = 1 - m_turn; m_to = 1; m_idle = 0; end
        end
      end
      2: if (s.rdy) m_ph = 3;
      3: if (s.rv) begin
        if (s.hit) begin
          if (m_fp == 1) m_sb++; else m_sa++;
        end
        m_ph = 4;
      end
      4: begin
        sc = (m_fp == 1) ? m_sb : m_sa;
        if (sc == WIN) begin m_ph = 5; m_go = 1; m_win = m_fp; end
        else begin m_turn = 1 - m_turn; m_ph = 1; m_idle = 0; end
      end
      5: if (s.start) begin m_ph = 0; m_go = 0; m_sa = 0; m_sb = 0; end
      default: m_ph = 0;
    endcase
  endtask

  function automatic logic [19:0] pack_model();
    return {3'(m_ph), 1'(m_turn), 3'(m_sa), 3'(m_sb), 1'(m_ph == 2), 1'(m_fp),
            2'(m_fx), 2'(m_fy), 1'(m_go), 1'(m_win), 1'(m_ill), 1'(m_to)};
  endfunction

  function automatic logic [19:0] pack_dut();
    return {state, turn, score_a, score_b, fire_valid, fire_player, fire_x, fire_y,
            game_over, winner, illegal_pulse, timeout_pulse};
  endfunction

  // Drive one cycle's inputs, let the edge happen, then sample 1 ns later.
  task automatic step(input stim_t s);
    rst = s.r; start = s.start; pA_req = s.pa; pB_req = s.pb; X = s.x; Y = s.y;
    fire_ready = s.rdy; result_valid = s.rv; result_hit = s.hit;
    @(posedge clk);
    #1;
    model_step(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk_s(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 0; pA_req = 0; pB_req = 0; X = 0; Y = 0;
    fire_ready = 0; result_valid = 0; result_hit = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = mk_v(mk_s(1,0,0,0,0,0,0,0), 1,0,0,0, 0,0,0,0, 0,0);
    vecs[1]  = mk_v(mk_s(0,0,1,2,1,0,0,0), 1,0,0,0, 0,0,0,0, 1,0);
    vecs[2]  = mk_v(mk_s(0,0,0,0,0,0,1,1), 1,0,0,0, 0,0,0,0, 0,0);
    vecs[3]  = mk_v(mk_s(0,1,0,3,0,0,0,0), 2,0,0,0, 1,0,3,0, 0,0);
    vecs[4]  = mk_v(mk_s(0,0,1,1,2,0,0,0), 2,0,0,0, 1,0,3,0, 0,0);
    vecs[5]  = mk_v(mk_s(0,0,0,1,2,0,0,0), 2,0,0,0, 1,0,3,0, 0,0);
    vecs[6]  = mk_v(mk_s(0,0,0,2,3,0,1,1), 2,0,0,0, 1,0,3,0, 0,0);
    vecs[7]  = mk_v(mk_s(0,0,0,0,0,0,0,0), 2,0,0,0, 1,0,3,0, 0,0);
    vecs[8]  = mk_v(mk_s(0,0,0,0,0,1,0,0), 3,0,0,0, 0,0,3,0, 0,0);
    vecs[9]  = mk_v(mk_s(0,0,0,0,0,0,1,0), 4,0,0,0, 0,0,3,0, 0,0);
    vecs[10] = mk_v(mk_s(1,0,0,0,0,0,0,0), 1,1,0,0, 0,0,3,0, 0,0);
    vecs[11] = mk_v(mk_s(0,0,1,1,1,1,0,0), 2,1,0,0, 1,1,1,1, 0,0);
    vecs[12] = mk_v(mk_s(1,0,0,0,0,1,0,0), 3,1,0,0, 0,1,1,1, 0,0);
    vecs[13] = mk_v(mk_s(0,0,0,0,0,0,1,1), 4,1,0,1, 0,1,1,1, 0,0);
    vecs[14] = mk_v(mk_s(0,0,0,0,0,0,0,0), 1,0,0,1, 0,1,1,1, 0,0);
    vecs[15] = mk_v(mk_s(0,1,1,2,2,1,0,0), 2,0,0,1, 1,0,2,2, 1,0);
    vecs[16] = mk_v(mk_s(0,0,0,0,0,1,0,0), 3,0,0,1, 0,0,2,2, 0,0);
    vecs[17] = mk_v(mk_s(0,0,0,0,0,0,1,1), 4,0,1,1, 0,0,2,2, 0,0);
    vecs[18] = mk_v(mk_s(0,0,0,0,0,0,0,0), 1,1,1,1, 0,0,2,2, 0,0);

    do_reset();
    check("reset_state", state, 0);
    check("reset_outputs", pack_dut(), 20'h0);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].s);
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_turn", i), turn, vecs[i].tn);
      check($sformatf("v%0d_scores", i), {score_a, score_b}, {vecs[i].sa, vecs[i].sb});
      check($sformatf("v%0d_fire", i), {fire_valid, fire_player, fire_x, fire_y},
            {vecs[i].fv, vecs[i].fp, vecs[i].fx, vecs[i].fy});
      check($sformatf("v%0d_illegal", i), illegal_pulse, vecs[i].ill);
      check($sformatf("v%0d_game_over", i), game_over, vecs[i].go);
    end

    // Win and restart: B misses, A scores the second hit.
    step(mk_s(0,0,1,0,3,1,0,0));
    step(mk_s(0,0,0,0,0,1,0,0));
    step(mk_s(0,0,0,0,0,0,1,0));
    step(mk_s(0,0,0,0,0,0,0,0));
    check("win_turn_back_to_a", turn, 0);
    step(mk_s(0,1,0,1,1,1,0,0));
    step(mk_s(0,0,0,0,0,1,0,0));
    step(mk_s(0,0,0,0,0,0,1,1));
    check("win_r1_score_a", score_a, 2);
    check("win_r1_not_over_yet", game_over, 0);
    step(mk_s(0,0,0,0,0,0,0,0));
    check("win_state", state, 5);
    check("win_game_over", game_over, 1);
    check("win_winner", winner, 0);
    check("win_scores", {score_a, score_b}, {3'd2, 3'd1});
    step(mk_s(0,0,0,0,0,0,1,1));
    check("over_holds", {state, game_over, score_a}, {3'd5, 1'b1, 3'd2});
    step(mk_s(1,0,0,0,0,0,0,0));
    check("restart_idle", {state, game_over, score_a, score_b}, {3'd0, 1'b0, 3'd0, 3'd0});
    step(mk_s(1,0,0,0,0,0,0,0));
    check("restart_armed", {state, turn}, {3'd1, 1'b0});

    // Asynchronous reset in the middle of a handshake.
    step(mk_s(0,1,0,3,2,0,0,0));
    check("pre_reset_issue", {state, fire_valid}, {3'd2, 1'b1});
    #3 rst = 1'b1;
    #1;
    check("async_reset_fire_valid", fire_valid, 0);
    check("async_reset_all", pack_dut(), 20'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

`ifdef TURN_TIMEOUT_EN
    step(mk_s(1,0,0,0,0,0,0,0));
    idle(TMO - 1);
    check("to_not_yet", {timeout_pulse, turn}, {1'b0, 1'b0});
    idle(1);
    check("to_fires", {timeout_pulse, turn, state}, {1'b1, 1'b1, 3'd1});
    idle(1);
    check("to_one_cycle", {timeout_pulse, turn}, {1'b0, 1'b1});
    idle(TMO - 2);
    step(mk_s(0,0,1,2,3,1,0,0));
    check("to_expiry_accept", {state, timeout_pulse, fire_player, fire_x, fire_y},
          {3'd2, 1'b0, 1'b1, 2'd2, 2'd3});
    step(mk_s(0,0,0,0,0,1,0,0));
    check("to_expiry_no_pulse", timeout_pulse, 0);
`else
    step(mk_s(1,0,0,0,0,0,0,0));
    idle(3 * TMO);
    check("no_timeout_waits", {state, turn, timeout_pulse}, {3'd1, 1'b0, 1'b0});
`endif

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.r     = ($urandom_range(0, 499) == 0);
      s.start = ($urandom_range(0, 15) == 0);
      s.pa    = ($urandom_range(0, 3) == 0);
      s.pb    = ($urandom_range(0, 3) == 0);
      s.x     = 2'($urandom_range(0, 3));
      s.y     = 2'($urandom_range(0, 3));
      s.rdy   = ($urandom_range(0, 1) == 0);
      s.rv    = ($urandom_range(0, 2) == 0);
      s.hit   = ($urandom_range(0, 1) == 0);
      step(s);
      check($sformatf("rand%0d_outputs", i), pack_dut(), pack_model());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
